// File: rtl/key_event_queue_pkg.sv
// Shared key-code constants, FSM state encoding and small helpers for the
// keyboard event queue.
package key_event_queue_pkg;

  localparam int KEY_W = 16;

  localparam logic [KEY_W-1:0] KEY_NEWLINE   = 16'd128;
  localparam logic [KEY_W-1:0] KEY_BACKSPACE = 16'd129;
  localparam logic [KEY_W-1:0] KEY_TAB       = 16'd130;
  localparam logic [KEY_W-1:0] KEY_ESC       = 16'd131;
  localparam logic [KEY_W-1:0] KEY_UP        = 16'd132;
  localparam logic [KEY_W-1:0] KEY_DOWN      = 16'd133;
  localparam logic [KEY_W-1:0] KEY_LEFT      = 16'd134;
  localparam logic [KEY_W-1:0] KEY_RIGHT     = 16'd135;
  localparam logic [KEY_W-1:0] KEY_HOME      = 16'd136;
  localparam logic [KEY_W-1:0] KEY_END       = 16'd137;
  localparam logic [KEY_W-1:0] KEY_PGUP      = 16'd138;
  localparam logic [KEY_W-1:0] KEY_PGDN      = 16'd139;
  localparam logic [KEY_W-1:0] KEY_INSERT    = 16'd140;
  localparam logic [KEY_W-1:0] KEY_F1        = 16'd141;
  localparam logic [KEY_W-1:0] KEY_F12       = 16'd152;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } kbd_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_event_queue_sync_fifo.sv
// Generic synchronous FIFO with first-word-fall-through head and wrap-bit
// pointers; reports pushes dropped because the FIFO was full.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                 (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign count = wr_ptr_r - rd_ptr_r;

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign drop      = push & full & ~do_pop_s;

  assign head = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/key_event_queue.sv
// Turns a level key code into discrete press events with typematic
// auto-repeat, buffered in a FIFO the CPU drains with a pop strobe.
module key_event_queue
  import key_event_queue_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int DELAY_CYCLES  = 12562500,
  parameter int REPEAT_CYCLES = 837500,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [KEY_W-1:0]       key_in,
  input  logic                   pop,
  output logic [KEY_W-1:0]       out,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int TMR_W = $clog2(max_int(DELAY_CYCLES, REPEAT_CYCLES));
  localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(DELAY_CYCLES - 1);
  localparam logic [TMR_W-1:0] REP_LAST = TMR_W'(REPEAT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  kbd_state_e       state_r, state_nxt_s;
  logic [TMR_W-1:0] timer_r, timer_nxt_s;
  logic [KEY_W-1:0] key_q_r;
  logic             press_s;
  logic             push_s;
  logic             release_s;
  logic             drop_s;
  logic             full_s;
  logic             empty_s;
  logic             overflow_r;

  assign release_s = (key_in == {KEY_W{1'b0}});
  assign press_s   = !release_s && (key_in != key_q_r);

  // Key history, FSM state, repeat timer and overflow pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q_r    <= {KEY_W{1'b0}};
      state_r    <= ST_IDLE;
      timer_r    <= {TMR_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      key_q_r    <= key_in;
      state_r    <= state_nxt_s;
      timer_r    <= timer_nxt_s;
      overflow_r <= drop_s;
    end
  end

  // Next state: release beats code change, which beats timer expiry
  always_comb begin
    state_nxt_s = state_r;
    timer_nxt_s = timer_r;
    push_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (press_s) begin
          push_s      = 1'b1;
          timer_nxt_s = {TMR_W{1'b0}};
          state_nxt_s = ST_HOLD;
        end else begin
          timer_nxt_s = {TMR_W{1'b0}};
        end
      end
      ST_HOLD: begin
        if (release_s) begin
          timer_nxt_s = {TMR_W{1'b0}};
          state_nxt_s = ST_IDLE;
        end else if (press_s) begin
          push_s      = 1'b1;
          timer_nxt_s = {TMR_W{1'b0}};
        end else if (timer_r == DLY_LAST) begin
          if (REPEAT_EN) begin
            push_s      = 1'b1;
            timer_nxt_s = {TMR_W{1'b0}};
            state_nxt_s = ST_REPEAT;
          end else begin
            timer_nxt_s = timer_r;
          end
        end else begin
          timer_nxt_s = timer_r + TMR_ONE;
        end
      end
      ST_REPEAT: begin
        if (release_s) begin
          timer_nxt_s = {TMR_W{1'b0}};
          state_nxt_s = ST_IDLE;
        end else if (press_s) begin
          push_s      = 1'b1;
          timer_nxt_s = {TMR_W{1'b0}};
          state_nxt_s = ST_HOLD;
        end else if (timer_r == REP_LAST) begin
          push_s      = 1'b1;
          timer_nxt_s = {TMR_W{1'b0}};
        end else begin
          timer_nxt_s = timer_r + TMR_ONE;
        end
      end
      default: begin
        timer_nxt_s = {TMR_W{1'b0}};
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  sync_fifo #(
    .WIDTH (KEY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop),
    .din   (key_in),
    .head  (out),
    .full  (full_s),
    .empty (empty_s),
    .count (count),
    .drop  (drop_s)
  );

  assign valid    = !empty_s;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed plus randomized bench for key_event_queue: one instance with
// auto-repeat, one without, both checked against a cycle-level event model.
module tb_key_event_queue;

  localparam int DEPTH = 4;
  localparam int DLY   = 10;
  localparam int REP   = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic [15:0]   key_in;
  logic          pop;
  logic [15:0]   out0, out1;
  logic          valid0, valid1;
  logic [CW-1:0] count0, count1;
  logic          ovf0, ovf1;

  int nvec;
  int nerr;

  // model state, index 0 = repeat enabled, 1 = repeat disabled
  logic [15:0] m_prev [2];
  int          m_age  [2];
  bit          m_rep  [2];
  logic [15:0] m_buf  [2][DEPTH];
  int          m_hd   [2];
  int          m_sz   [2];
  bit          m_ovf  [2];

  key_event_queue #(.DEPTH(DEPTH), .DELAY_CYCLES(DLY), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .pop(pop),
    .out(out0), .valid(valid0), .count(count0), .overflow(ovf0));

  key_event_queue #(.DEPTH(DEPTH), .DELAY_CYCLES(DLY), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b0)) dut_norep (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .pop(pop),
    .out(out1), .valid(valid1), .count(count1), .overflow(ovf1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_prev[m] = 16'd0;
      m_age[m]  = 0;
      m_rep[m]  = 1'b0;
      m_hd[m]   = 0;
      m_sz[m]   = 0;
      m_ovf[m]  = 1'b0;
    end
  endtask

  // One clock edge of the intended behaviour: event generation, then queue.
  task automatic model_edge(input int m, input logic [15:0] k, input logic p);
    bit ev;
    bit do_pop;
    ev     = 1'b0;
    do_pop = p && (m_sz[m] > 0);
    if (k != 16'd0) begin
      if (k != m_prev[m]) begin
        ev = 1'b1; m_age[m] = 0; m_rep[m] = 1'b0;
      end else begin
        m_age[m]++;
        if (!m_rep[m] && m_age[m] == DLY) begin
          if (m == 0) begin ev = 1'b1; m_rep[m] = 1'b1; m_age[m] = 0; end
        end else if (m_rep[m] && m_age[m] == REP) begin
          ev = 1'b1; m_age[m] = 0;
        end
      end
    end
    m_prev[m] = k;
    if (do_pop) begin
      m_hd[m] = (m_hd[m] + 1) % DEPTH;
      m_sz[m]--;
    end
    m_ovf[m] = 1'b0;
    if (ev) begin
      if (m_sz[m] < DEPTH) begin
        m_buf[m][(m_hd[m] + m_sz[m]) % DEPTH] = k;
        m_sz[m]++;
      end else begin
        m_ovf[m] = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    logic [15:0] e0, e1;
    e0 = (m_sz[0] > 0) ? m_buf[0][m_hd[0]] : 16'd0;
    e1 = (m_sz[1] > 0) ? m_buf[1][m_hd[1]] : 16'd0;
    chk("out_rep",      32'(out0),   32'(e0));
    chk("valid_rep",    32'(valid0), 32'(m_sz[0] > 0));
    chk("count_rep",    32'(count0), 32'(m_sz[0]));
    chk("ovf_rep",      32'(ovf0),   32'(m_ovf[0]));
    chk("out_norep",    32'(out1),   32'(e1));
    chk("valid_norep",  32'(valid1), 32'(m_sz[1] > 0));
    chk("count_norep",  32'(count1), 32'(m_sz[1]));
    chk("ovf_norep",    32'(ovf1),   32'(m_ovf[1]));
  endtask

  task automatic step(input logic [15:0] k, input logic p);
    key_in = k;
    pop    = p;
    @(posedge clk);
    model_edge(0, k, p);
    model_edge(1, k, p);
    #1;
    check_model();
  endtask

  task automatic do_reset(input logic [15:0] k);
    key_in = k;
    pop    = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("rst_out",   32'(out0),   32'd0);
    chk("rst_valid", 32'(valid0), 32'd0);
    chk("rst_count", 32'(count0), 32'd0);
    chk("rst_ovf",   32'(ovf0),   32'd0);
  endtask

  initial begin
    int ovf_hits;
    int hold;
    logic [15:0] k;
    nvec   = 0;
    nerr   = 0;
    rst_n  = 1'b0;
    key_in = 16'd0;
    pop    = 1'b0;
    model_reset();

    // reset with 'a' held, then the first edge records a fresh press
    do_reset(16'h0061);
    step(16'h0061, 1'b0);
    chk("t1_out",   32'(out0),   32'h61);
    chk("t1_count", 32'(count0), 32'd1);

    // keep holding: repeats at +10,+14,+18 fill, +22/+26 are dropped
    ovf_hits = 0;
    for (int i = 1; i < 30; i++) begin
      step(16'h0061, 1'b0);
      if (ovf0) ovf_hits++;
    end
    chk("t2_count",    32'(count0), 32'd4);
    chk("t2_ovf_hits", 32'(ovf_hits), 32'd2);

    // code change restarts the delay
    do_reset(16'h0000);
    step(16'h0061, 1'b0);
    for (int i = 0; i < 5; i++) step(16'h0061, 1'b0);
    step(16'h0062, 1'b0);
    for (int i = 0; i < 9; i++) step(16'h0062, 1'b0);
    chk("t3_count_b9", 32'(count0), 32'd2);
    step(16'h0062, 1'b0);
    chk("t3_count_b10", 32'(count0), 32'd3);
    for (int i = 0; i < 4; i++) step(16'h0062, 1'b0);
    chk("t4_full", 32'(count0), 32'd4);

    // full FIFO, push and pop on the same edge
    step(16'h0063, 1'b1);
    chk("t4_count", 32'(count0), 32'd4);
    chk("t4_ovf",   32'(ovf0),   32'd0);
    chk("t4_out",   32'(out0),   32'h62);

    // empty FIFO pops
    do_reset(16'h0000);
    step(16'h0000, 1'b1);
    chk("t5_valid", 32'(valid0), 32'd0);
    step(16'h0064, 1'b1);
    chk("t5_count", 32'(count0), 32'd1);
    chk("t5_out",   32'(out0),   32'h64);

    // repeat disabled: one event per press
    do_reset(16'h0000);
    step(16'h0061, 1'b0);
    for (int i = 0; i < 50; i++) step(16'h0061, 1'b0);
    chk("t6_count_hold", 32'(count1), 32'd1);
    step(16'h0000, 1'b0);
    step(16'h0061, 1'b0);
    chk("t6_count_repress", 32'(count1), 32'd2);

    // randomized holds, code changes and pops
    do_reset(16'h0000);
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0:       k = 16'h0000;
        1:       k = 16'h0061;
        2:       k = 16'h0062;
        default: k = 16'd152;
      endcase
      hold = int'($urandom_range(1, 30));
      for (int j = 0; j < hold; j++) step(k, ($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
